spi_slave_ctrl: RTL and testbench
=================================

# spi_slave_ctrl

SPI target-side (slave) controller: the far end of the SPI link driven by our master FSM. Oversamples external SCLK/CS_N/MOSI in the i_clk domain, shifts one DATA_W-bit frame per transfer, pops outgoing words from a first-word-fall-through TX FIFO and pushes received words into an RX FIFO. It sits between the SPI pads and the APB register/FIFO block of the slave-side peripheral.

## Interface
- DATA_W, 8, frame length in bits; legal 4..32
- i_clk  in  1  system clock; must be ≥ 8× f_SCLK
- i_rst_n  in  1  reset, asynchronous, active-low
- i_cpol  in  1  SCLK idle level; static while CS_N low
- i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- i_lsb_first  in  1  1: LSB shifted first; 0: MSB first
- i_sclk  in  1  SPI clock pin, asynchronous
- i_cs_n  in  1  chip select pin, active-low, asynchronous
- i_mosi  in  1  data-in pin, asynchronous
- o_miso  out  1  data-out pin value
- o_miso_oe  out  1  MISO output enable (= synchronized CS active)
- i_tx_data  in  DATA_W  TX FIFO head word (FWFT)
- i_tx_empty  in  1  TX FIFO empty
- o_tx_rd  out  1  TX FIFO pop, 1-cycle pulse
- o_rx_data  out  DATA_W  received word, valid with o_rx_wr
- o_rx_wr  out  1  RX FIFO push, 1-cycle pulse
- i_rx_full  in  1  RX FIFO full
- o_tx_underrun  out  1  pulse: frame loaded while TX empty
- o_rx_overrun  out  1  pulse: completed word dropped, RX full
- o_frame_abort  out  1  pulse: CS_N released mid-frame
- o_state  out  2  FSM state (debug/status)
- o_busy  out  1  o_state != IDLE

## Operation
- Sync: i_sclk, i_cs_n, i_mosi each through 2-FF synchronizer; SCLK additionally edge-detected (1 register). cs_act = synchronized ~cs_n.
- Leading edge = SCLK leaves i_cpol level; trailing = returns to it. Sample edge = leading if i_cpha=0 else trailing; shift edge = the other.
- States (2-bit): IDLE=00, LOAD=01, SHIFT=10, DONE=11.
- IDLE: all edges ignored; cs_act rising -> LOAD.
- LOAD (1 cycle): if !i_tx_empty, shift_reg <= i_tx_data, o_tx_rd=1; else shift_reg <= all ones, o_tx_underrun=1. bit_cnt <= 0. -> SHIFT.
- SHIFT: sample edge: shift MOSI bit into rx_reg (position per i_lsb_first), bit_cnt+1; shift edge: advance shift_reg by one bit only if bit_cnt != 0 (uniform rule covers first bit for both CPHA and back-to-back frames). bit_cnt == DATA_W after a sample -> DONE.
- DONE (1 cycle): if !i_rx_full, o_rx_data <= rx_reg, o_rx_wr=1; else o_rx_overrun=1, word dropped. cs_act ? -> LOAD : -> IDLE.
- o_miso = current output bit of shift_reg (MSB, or LSB when i_lsb_first). Updated in LOAD and on shift edges only.
- bit_cnt width $clog2(DATA_W+1); never wraps, cleared in LOAD.

## Timing
- Reset: state IDLE, shift_reg/rx_reg/bit_cnt = 0, o_miso=0, o_miso_oe=0, o_rx_data=0, all pulses 0.
- Pin edge -> internal edge pulse: 3 i_clk cycles; shift edge -> o_miso change: +1 cycle (≤4 cycles pin-to-pin, hence 8× clock ratio).
- CS_N fall -> LOAD at cycle 3 after pin edge; first bit on o_miso at cycle 4.
- Last sample edge -> o_rx_wr: 2 cycles (DONE after sample cycle). Next frame's bit 0 on o_miso 1 cycle later.
- Shift edges occurring in DONE/LOAD are dropped (equivalent to bit_cnt==0 rule).
- cs_act falls in SHIFT: -> IDLE next cycle; o_frame_abort pulses iff bit_cnt != 0; partial rx_reg discarded, popped TX word lost; no o_rx_wr.
- cs_act falls in DONE: the RX write still completes, then IDLE. Falls in LOAD: pop still occurs, SHIFT then IDLE next cycle, no abort pulse (bit_cnt=0).
- cs_act fall and SCLK edge in same cycle: CS wins, edge ignored.
- Reset mid-frame: immediate return to reset values; no FIFO strobes.

## Structure
- spi_pkg: state encodings (shared with spi_fsm_ctrl IDLE/LOAD/TRANSFER/DONE naming), DATA_W default, edge-select helper function.
- One sub-module: spi_slave_sync — parameterized 2-FF synchronizer with optional rise/fall pulse outputs; instantiated for SCLK (with edges), CS_N, MOSI.

## Test plan
- Mode 0, MSB first, TX 0xA5, master sends 0x3C -> MISO bits 1,0,1,0,0,1,0,1; o_rx_data=0x3C with one o_rx_wr; one o_tx_rd.
- Modes 1/2/3 and LSB first, TX 0x81, MOSI 0x7E -> master reads 0x81, o_rx_data=0x7E in every mode.
- CS held low for 3 frames, TX FIFO 0x11,0x22,0x33 -> three pops, three pushes, no gaps/bit slips on MISO.
- TX empty at CS fall -> MISO 0xFF, o_tx_underrun one pulse; RX full at frame end -> no o_rx_wr, o_rx_overrun one pulse.
- CS_N released after 5 bits -> o_frame_abort pulse, no o_rx_wr, state IDLE; next full frame receives correctly.
- Async reset asserted mid-SHIFT -> all outputs at reset values within same cycle, o_miso_oe=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target-side controller.
package spi_pkg;

    localparam int DATA_W_DEF = 8;

    // Encodings line up with the master-side FSM: its TRANSFER slot is SHIFT here.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } spi_state_e;

    // CPHA=0 samples on the leading edge, CPHA=1 on the trailing edge.
    function automatic logic sample_edge_sel(input logic cpha, input logic lead, input logic trail);
        return cpha ? trail : lead;
    endfunction

    // The shift edge is always the one not used for sampling.
    function automatic logic shift_edge_sel(input logic cpha, input logic lead, input logic trail);
        return cpha ? lead : trail;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for an asynchronous pin, with optional edge pulses
// derived from one extra history flop.
module spi_slave_sync #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGES   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values for the synchronizer chain.
    always_comb begin
        meta_d = i_async;
        sync_d = meta_q;
    end

    // Synchronizer chain; resets to the pin's inactive level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_sync = sync_q;

    generate
        if (EDGES) begin : g_edge
            logic prev_d, prev_q;

            // History value for edge detection.
            always_comb begin
                prev_d = sync_q;
            end

            // History flop; edge pulses are combinational from it.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    prev_q <= RST_VAL;
                end else begin
                    prev_q <= prev_d;
                end
            end

            assign o_rise = sync_q & ~prev_q;
            assign o_fall = ~sync_q & prev_q;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI target-side controller: oversamples the SPI pins, shifts one frame per
// transfer, pops TX words from an FWFT FIFO and pushes RX words to a FIFO.
//
//   state | meaning
//   IDLE  | CS inactive, all SCLK edges ignored
//   LOAD  | one cycle: latch TX head (or all ones on underrun), clear bit count
//   SHIFT | sample/shift on SCLK edges until DATA_W bits sampled
//   DONE  | one cycle: push RX word (or flag overrun), reload if CS still active
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsb_first,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_empty,
    output logic              o_tx_rd,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_wr,
    input  logic              i_rx_full,
    output logic              o_tx_underrun,
    output logic              o_rx_overrun,
    output logic              o_frame_abort,
    output logic [1:0]        o_state,
    output logic              o_busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    logic sclk_lvl_unused;
    logic sclk_rise, sclk_fall;
    logic cs_n_s, cs_rise_unused, cs_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sclk),
        .o_sync  (sclk_lvl_unused),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    spi_slave_sync #(.RST_VAL(1'b1), .EDGES(1'b0)) u_sync_cs (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_cs_n),
        .o_sync  (cs_n_s),
        .o_rise  (cs_rise_unused),
        .o_fall  (cs_fall_unused)
    );

    spi_slave_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_mosi),
        .o_sync  (mosi_s),
        .o_rise  (mosi_rise_unused),
        .o_fall  (mosi_fall_unused)
    );

    logic cs_act;
    logic lead_edge, trail_edge;
    logic sample_edge, shift_edge;

    assign cs_act      = ~cs_n_s;
    assign lead_edge   = i_cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = i_cpol ? sclk_rise : sclk_fall;
    assign sample_edge = sample_edge_sel(i_cpha, lead_edge, trail_edge);
    assign shift_edge  = shift_edge_sel(i_cpha, lead_edge, trail_edge);

    spi_state_e        state_d, state_q;
    logic [DATA_W-1:0] shift_reg_d, shift_reg_q;
    logic [DATA_W-1:0] rx_reg_d, rx_reg_q;
    logic [CNT_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic [DATA_W-1:0] rx_data_d, rx_data_q;
    logic              rx_wr_d, rx_wr_q;
    logic              rx_overrun_d, rx_overrun_q;
    logic              frame_abort_d, frame_abort_q;
    logic              tx_rd, tx_underrun;

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d       = state_q;
        shift_reg_d   = shift_reg_q;
        rx_reg_d      = rx_reg_q;
        bit_cnt_d     = bit_cnt_q;
        rx_data_d     = rx_data_q;
        rx_wr_d       = 1'b0;
        rx_overrun_d  = 1'b0;
        frame_abort_d = 1'b0;
        tx_rd         = 1'b0;
        tx_underrun   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_act) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (!i_tx_empty) begin
                    shift_reg_d = i_tx_data;
                    tx_rd       = 1'b1;
                end else begin
                    shift_reg_d = '1;
                    tx_underrun = 1'b1;
                end
                bit_cnt_d = '0;
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                // CS release wins over any SCLK edge seen in the same cycle.
                if (!cs_act) begin
                    state_d       = ST_IDLE;
                    frame_abort_d = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    if (i_lsb_first) begin
                        rx_reg_d = {mosi_s, rx_reg_q[DATA_W-1:1]};
                    end else begin
                        rx_reg_d = {rx_reg_q[DATA_W-2:0], mosi_s};
                    end
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_d == CNT_LAST) begin
                        state_d = ST_DONE;
                    end
                end else if (shift_edge && (bit_cnt_q != '0)) begin
                    // Bit 0 is already on MISO from LOAD, so the first shift
                    // edge of a frame is skipped in every mode.
                    if (i_lsb_first) begin
                        shift_reg_d = {1'b0, shift_reg_q[DATA_W-1:1]};
                    end else begin
                        shift_reg_d = {shift_reg_q[DATA_W-2:0], 1'b0};
                    end
                end
            end

            ST_DONE: begin
                if (!i_rx_full) begin
                    rx_data_d = rx_reg_q;
                    rx_wr_d   = 1'b1;
                end else begin
                    rx_overrun_d = 1'b1;
                end
                state_d = cs_act ? ST_LOAD : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            shift_reg_q   <= '0;
            rx_reg_q      <= '0;
            bit_cnt_q     <= '0;
            rx_data_q     <= '0;
            rx_wr_q       <= 1'b0;
            rx_overrun_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_reg_q   <= shift_reg_d;
            rx_reg_q      <= rx_reg_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_data_q     <= rx_data_d;
            rx_wr_q       <= rx_wr_d;
            rx_overrun_q  <= rx_overrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    // TX pop is issued while LOAD latches the FWFT head, so the FIFO advances
    // on the same edge the word is captured.
    assign o_tx_rd       = tx_rd;
    assign o_tx_underrun = tx_underrun;

    assign o_miso        = i_lsb_first ? shift_reg_q[0] : shift_reg_q[DATA_W-1];
    assign o_miso_oe     = cs_act;
    assign o_rx_data     = rx_data_q;
    assign o_rx_wr       = rx_wr_q;
    assign o_rx_overrun  = rx_overrun_q;
    assign o_frame_abort = frame_abort_q;
    assign o_state       = state_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: bench acts as SPI master and as both FIFOs.
module tb_spi_slave_ctrl;

    localparam int W = 8;
    localparam int H = 8;   // i_clk cycles per SCLK half period

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
    logic         sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic         miso, miso_oe;
    logic [W-1:0] tx_data;
    logic         tx_empty, tx_rd;
    logic [W-1:0] rx_data;
    logic         rx_wr;
    logic         rx_full = 1'b0;
    logic         underrun, overrun, abort_p;
    logic [1:0]   state;
    logic         busy;

    always #5 clk = ~clk;

    spi_slave_ctrl #(.DATA_W(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_cpol        (cpol),
        .i_cpha        (cpha),
        .i_lsb_first   (lsb),
        .i_sclk        (sclk),
        .i_cs_n        (cs_n),
        .i_mosi        (mosi),
        .o_miso        (miso),
        .o_miso_oe     (miso_oe),
        .i_tx_data     (tx_data),
        .i_tx_empty    (tx_empty),
        .o_tx_rd       (tx_rd),
        .o_rx_data     (rx_data),
        .o_rx_wr       (rx_wr),
        .i_rx_full     (rx_full),
        .o_tx_underrun (underrun),
        .o_rx_overrun  (overrun),
        .o_frame_abort (abort_p),
        .o_state       (state),
        .o_busy        (busy)
    );

    // TX FIFO model (FWFT): bench pushes, DUT pops.
    logic [W-1:0] tx_mem [0:15];
    logic [3:0]   tx_wr_ptr = '0;
    logic [3:0]   tx_rd_ptr = '0;
    assign tx_data  = tx_mem[tx_rd_ptr];
    assign tx_empty = (tx_wr_ptr == tx_rd_ptr);

    always @(posedge clk) begin
        if (tx_rd) tx_rd_ptr <= tx_rd_ptr + 4'd1;
    end

    // Strobe counters and RX log.
    int           n_rx_wr = 0, n_tx_rd = 0, n_under = 0, n_over = 0, n_abort = 0;
    logic [W-1:0] rx_log [0:31];

    always @(negedge clk) begin
        if (rx_wr) begin
            rx_log[n_rx_wr[4:0]] <= rx_data;
            n_rx_wr <= n_rx_wr + 1;
        end
        if (tx_rd)    n_tx_rd <= n_tx_rd + 1;
        if (underrun) n_under <= n_under + 1;
        if (overrun)  n_over  <= n_over + 1;
        if (abort_p)  n_abort <= n_abort + 1;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        tx_mem[tx_wr_ptr] = w;
        tx_wr_ptr = tx_wr_ptr + 4'd1;
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l);
        cpol = p;
        cpha = h;
        lsb  = l;
        sclk = p;
        tick(4);
    endtask

    // Master side of nbits bit-times; CS is handled by the caller.
    task automatic frame(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
        int idx;
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = lsb ? i : W - 1 - i;
            if (!cpha) begin
                mosi = mo[idx];
                tick(H);
                sclk = ~cpol;
                mi[idx] = miso;
                tick(H);
                sclk = cpol;
            end else begin
                tick(H);
                sclk = ~cpol;
                mosi = mo[idx];
                tick(H);
                sclk = cpol;
                mi[idx] = miso;
            end
        end
        tick(H);
    endtask

    typedef struct {
        logic         cpol;
        logic         cpha;
        logic         lsb;
        logic [W-1:0] tx;
        logic [W-1:0] mo;
        logic [W-1:0] exp_mi;
        logic [W-1:0] exp_rx;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] mi;
        int b_rx, b_tx, b_under, b_over, b_abort;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};

        // Reset values
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_miso_oe", 32'(miso_oe), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_wr", 32'(rx_wr), 32'd0);
        rst_n = 1'b1;
        tick(3);

        // Single frames in each mode / bit order
        b_abort = n_abort;
        for (int k = 0; k < 9; k++) begin
            set_mode(vecs[k].cpol, vecs[k].cpha, vecs[k].lsb);
            push_tx(vecs[k].tx);
            b_rx = n_rx_wr;
            b_tx = n_tx_rd;
            cs_n = 1'b0;
            frame(vecs[k].mo, W, mi);
            cs_n = 1'b1;
            tick(2 * H);
            check($sformatf("v%0d_miso_word", k), 32'(mi), 32'(vecs[k].exp_mi));
            check($sformatf("v%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_rx));
            check($sformatf("v%0d_rx_wr_cnt", k), 32'(n_rx_wr - b_rx), 32'd1);
            check($sformatf("v%0d_tx_rd_cnt", k), 32'(n_tx_rd - b_tx), 32'd1);
            check($sformatf("v%0d_state", k), 32'(state), 32'd0);
        end
        check("no_abort_on_clean_release", 32'(n_abort - b_abort), 32'd0);

        // Three back-to-back frames under one CS
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'h11);
        push_tx(8'h22);
        push_tx(8'h33);
        b_rx = n_rx_wr;
        b_tx = n_tx_rd;
        cs_n = 1'b0;
        frame(8'hC1, W, mi);
        check("b2b0_miso", 32'(mi), 32'h11);
        frame(8'hC2, W, mi);
        check("b2b1_miso", 32'(mi), 32'h22);
        frame(8'hC3, W, mi);
        check("b2b2_miso", 32'(mi), 32'h33);
        cs_n = 1'b1;
        tick(2 * H);
        check("b2b_rx_wr_cnt", 32'(n_rx_wr - b_rx), 32'd3);
        check("b2b_tx_rd_cnt", 32'(n_tx_rd - b_tx), 32'd3);
        check("b2b_rx0", 32'(rx_log[b_rx[4:0]]), 32'hC1);
        check("b2b_rx1", 32'(rx_log[5'(b_rx + 1)]), 32'hC2);
        check("b2b_rx2", 32'(rx_log[5'(b_rx + 2)]), 32'hC3);

        // TX underrun at CS fall
        set_mode(1'b0, 1'b1, 1'b0);
        b_under = n_under;
        b_tx = n_tx_rd;
        cs_n = 1'b0;
        tick(6);
        check("ur_under_cnt", 32'(n_under - b_under), 32'd1);
        check("ur_state_shift", 32'(state), 32'd2);
        check("ur_busy", 32'(busy), 32'd1);
        check("ur_miso_oe", 32'(miso_oe), 32'd1);
        frame(8'h5A, W, mi);
        cs_n = 1'b1;
        tick(2 * H);
        check("ur_miso_word", 32'(mi), 32'hFF);
        check("ur_rx_data", 32'(rx_data), 32'h5A);
        check("ur_tx_rd_cnt", 32'(n_tx_rd - b_tx), 32'd0);

        // RX overrun at frame end
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'h12);
        rx_full = 1'b1;
        b_rx = n_rx_wr;
        b_over = n_over;
        cs_n = 1'b0;
        frame(8'hE7, W, mi);
        cs_n = 1'b1;
        tick(2 * H);
        rx_full = 1'b0;
        check("ov_miso_word", 32'(mi), 32'h12);
        check("ov_rx_wr_cnt", 32'(n_rx_wr - b_rx), 32'd0);
        check("ov_over_cnt", 32'(n_over - b_over), 32'd1);
        check("ov_rx_data_held", 32'(rx_data), 32'h5A);

        // CS released after 5 bits, then a clean frame
        push_tx(8'h34);
        b_rx = n_rx_wr;
        b_tx = n_tx_rd;
        b_abort = n_abort;
        cs_n = 1'b0;
        frame(8'hF0, 5, mi);
        cs_n = 1'b1;
        tick(2 * H);
        check("ab_abort_cnt", 32'(n_abort - b_abort), 32'd1);
        check("ab_rx_wr_cnt", 32'(n_rx_wr - b_rx), 32'd0);
        check("ab_tx_rd_cnt", 32'(n_tx_rd - b_tx), 32'd1);
        check("ab_state", 32'(state), 32'd0);
        push_tx(8'h56);
        cs_n = 1'b0;
        frame(8'hA9, W, mi);
        cs_n = 1'b1;
        tick(2 * H);
        check("ab_next_miso", 32'(mi), 32'h56);
        check("ab_next_rx_data", 32'(rx_data), 32'hA9);
        check("ab_next_rx_wr_cnt", 32'(n_rx_wr - b_rx), 32'd1);

        // Asynchronous reset in the middle of SHIFT
        push_tx(8'h99);
        cs_n = 1'b0;
        frame(8'h0F, 3, mi);
        check("mr_pre_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mr_state", 32'(state), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_miso", 32'(miso), 32'd0);
        check("mr_miso_oe", 32'(miso_oe), 32'd0);
        check("mr_rx_data", 32'(rx_data), 32'd0);
        check("mr_rx_wr", 32'(rx_wr), 32'd0);
        cs_n = 1'b1;
        sclk = cpol;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("mr_post_state", 32'(state), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
